// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and frame payload types
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef struct packed {
    logic frame_err;
    logic parity_err;
  } uart_rx_flags_t;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic stop2;
  } uart_frame_cfg_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// Brings the asynchronous serial line into the clk domain and forms the 2-of-3
// majority over the current and two previous baud_tick samples.
module uart_rx_sampler #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx_in,
  output logic sample_c,
  output logic majority_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             hist_q;

  // Synchroniser resets to idle-high so reset never looks like a start edge
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '1;
      hist_q <= '1;
    end else if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      if (baud_tick) begin
        hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
      end
    end
  end

  assign sample_c   = sync_q[SYNC_STAGES-1];
  assign majority_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & sample_c) | (hist_q[0] & sample_c);

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: frame FSM, tick/bit counters and a one-deep
// valid/ready output register with overrun reporting.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned OVS         = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             rst,
  input  logic             rx_en,
  input  logic             baud_tick,
  input  logic             rx_in,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int unsigned       TICK_W      = $clog2(OVS);
  localparam int unsigned       BIT_W       = $clog2(WIDTH);
  localparam logic [TICK_W-1:0] TICK_DECIDE = TICK_W'(OVS / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(WIDTH - 1);

  logic sample_c;
  logic majority_c;

  uart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .arst_n    (arst_n),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx_in     (rx_in),
    .sample_c  (sample_c),
    .majority_c(majority_c)
  );

  uart_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  uart_frame_cfg_t   cfg_q, cfg_d;
  logic              par_err_q, par_err_d;
  logic              stop_err_q, stop_err_d;
  logic [WIDTH-1:0]  data_q, data_d;
  uart_rx_flags_t    flags_q, flags_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              decide_c, last_tick_c, deliver_c;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      cfg_q      <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      data_q     <= '0;
      flags_q    <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      cfg_q      <= cfg_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    cfg_d       = cfg_q;
    par_err_d   = par_err_q;
    stop_err_d  = stop_err_q;
    data_d      = data_q;
    flags_d     = flags_q;
    valid_d     = valid_q && !ready;
    overrun_d   = 1'b0;
    deliver_c   = 1'b0;
    decide_c    = baud_tick && (tick_q == TICK_DECIDE);
    last_tick_c = baud_tick && (tick_q == TICK_LAST);

    if (baud_tick && (state_q != ST_IDLE)) begin
      tick_d = last_tick_c ? '0 : tick_q + TICK_W'(1);
    end

    case (state_q)
      // The detecting tick is tick 0 of the start bit
      ST_IDLE: begin
        if (baud_tick && rx_en && !sample_c) begin
          state_d          = ST_START;
          tick_d           = TICK_W'(1);
          bit_d            = '0;
          cfg_d.parity_en  = parity_en;
          cfg_d.parity_odd = parity_odd;
          cfg_d.stop2      = stop2;
          par_err_d        = 1'b0;
          stop_err_d       = 1'b0;
        end
      end
      ST_START: begin
        if (decide_c && majority_c) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (last_tick_c) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (decide_c) begin
          shift_d = {majority_c, shift_q[WIDTH-1:1]};
        end
        if (last_tick_c) begin
          if (bit_q == BIT_LAST) begin
            state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (decide_c) begin
          par_err_d = ((^shift_q) ^ majority_c) != (cfg_q.parity_odd == PARITY_ODD);
        end
        if (last_tick_c) begin
          state_d = ST_STOP;
        end
      end
      // Leave at the last stop decision tick so a following start edge is not missed
      ST_STOP: begin
        if (decide_c) begin
          stop_err_d = stop_err_q | ~majority_c;
          if (bit_q == BIT_W'(cfg_q.stop2)) begin
            state_d   = ST_IDLE;
            tick_d    = '0;
            bit_d     = '0;
            deliver_c = 1'b1;
          end
        end else if (last_tick_c) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    if (!rx_en && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      tick_d    = '0;
      bit_d     = '0;
      deliver_c = 1'b0;
    end

    // A frame completing while the consumer is not taking the held one is dropped
    if (deliver_c) begin
      if (valid_q && !ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d             = shift_q;
        flags_d.frame_err  = stop_err_d;
        flags_d.parity_err = par_err_q;
        valid_d            = 1'b1;
      end
    end

    if (rst) begin
      state_d    = ST_IDLE;
      tick_d     = '0;
      bit_d      = '0;
      shift_d    = '0;
      cfg_d      = '0;
      par_err_d  = 1'b0;
      stop_err_d = 1'b0;
      data_d     = '0;
      flags_d    = '0;
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign frame_err  = flags_q.frame_err;
  assign parity_err = flags_q.parity_err;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed and randomized frames for uart_rx_ovs, checked against a frame-level
// model of the line protocol.
module tb_uart_rx_ovs;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OVS   = 16;
  localparam int unsigned DIV   = 4;
  localparam int MODE_NONE = 0;
  localparam int MODE_ARST = 1;
  localparam int MODE_RXEN = 2;

  logic             clk, arst_n, rst, rx_en, baud_tick, rx_in;
  logic             parity_en, parity_odd, stop2, ready;
  logic [WIDTH-1:0] data;
  logic             valid, busy, frame_err, parity_err, overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  logic [WIDTH+1:0] got_q[$];
  logic [WIDTH+1:0] exp_q[$];

  uart_rx_ovs #(
    .WIDTH(WIDTH),
    .OVS(OVS),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rst       (rst),
    .rx_en     (rx_en),
    .baud_tick (baud_tick),
    .rx_in     (rx_in),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .stop2     (stop2),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : tick_gen
    int unsigned cnt;
    cnt       = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      baud_tick = (cnt == DIV - 1);
      cnt       = (cnt + 1) % DIV;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // Consumer side: record every accepted word with its flags
  always @(posedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) got_q.push_back({data, frame_err, parity_err});
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    while (got_q.size() > 0) void'(got_q.pop_front());
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic wait_ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  // Expected {data, frame_err, parity_err} from the frame contents on the line
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] w, input bit pe, po, pb, s2,
                                             input bit [1:0] sb);
    int unsigned ones;
    bit perr, ferr;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) ones += 32'(w[i]);
    perr = pe && (((ones + 32'(pb)) % 2) != 32'(po));
    ferr = !sb[0] || (s2 && !sb[1]);
    return {w, ferr, perr};
  endfunction

  // Each line bit spans exactly OVS baud ticks, changed just after a tick
  task automatic send_frame(input logic [WIDTH-1:0] w, input bit pe, po, pb, s2, input bit [1:0] sb,
                            input bit chk_lat, input int mode, input int cut);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits.push_back(w[i]);
    if (pe) bits.push_back(pb);
    bits.push_back(sb[0]);
    if (s2) bits.push_back(sb[1]);
    parity_en  = pe;
    parity_odd = po;
    stop2      = s2;
    wait_ticks(1);
    @(negedge clk);
    for (int k = 0; k < bits.size(); k++) begin
      rx_in = bits[k];
      if (mode != MODE_NONE && k == cut) begin
        wait_ticks(OVS / 2);
        @(negedge clk);
        if (mode == MODE_ARST) begin
          arst_n = 1'b0;
          #1;
          check("arst_outputs_zero", {data, valid, busy, frame_err, parity_err, overrun}, 0);
          repeat (3) @(negedge clk);
          check("arst_held_zero", {data, valid, busy, frame_err, parity_err, overrun}, 0);
          rx_in  = 1'b1;
          arst_n = 1'b1;
          return;
        end
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("rx_en_drop_busy", busy, 0);
        wait_ticks(OVS / 2);
        @(negedge clk);
      end else if (chk_lat && k == bits.size() - 1) begin
        wait_ticks(OVS / 2 + 1);
        repeat (DIV - 1) @(posedge clk);
        #1;
        check("latency_valid_before", valid, 0);
        @(posedge clk);
        #1;
        check("latency_valid_rise", valid, 1);
        @(posedge clk);
        #1;
        check("valid_one_clk", valid, 0);
        wait_ticks(OVS / 2 - 2);
        @(negedge clk);
      end else begin
        wait_ticks(OVS);
        @(negedge clk);
      end
    end
    rx_in = 1'b1;
    if (mode == MODE_RXEN) rx_en = 1'b1;
    wait_ticks(OVS);
    @(negedge clk);
  endtask

  initial begin
    int ovr_base;
    arst_n = 1'b0; rst = 1'b0; rx_en = 1'b1; rx_in = 1'b1; ready = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {data, valid, busy, frame_err, parity_err, overrun}, 0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", {data, valid, busy, frame_err, parity_err, overrun}, 0);

    // 0xA5, no parity, one stop, with delivery latency
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 0, 0, 0, 0, 2'b11, 1, MODE_NONE, 0);
    check_sb("frame_a5");

    // 0x3C even parity, wrong then right parity bit
    exp_q.push_back({8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1, 0, 1, 0, 2'b11, 0, MODE_NONE, 0);
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1, 0, 0, 0, 2'b11, 0, MODE_NONE, 0);
    check_sb("parity_3c");

    // 0x81, two stop bits with the second one low
    ready = 1'b0;
    send_frame(8'h81, 0, 0, 0, 1, 2'b01, 0, MODE_NONE, 0);
    check("stop2_data", data, 8'h81);
    check("stop2_frame_err", frame_err, 1);
    check("stop2_parity_err", parity_err, 0);
    check("stop2_valid", valid, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("stop2_valid_clear", valid, 0);
    exp_q.push_back({8'h81, 1'b1, 1'b0});
    check_sb("stop2_81");

    // Overrun: second frame dropped while the first is held
    @(negedge clk);
    ready    = 1'b0;
    ovr_base = ovr_cnt;
    send_frame(8'h11, 0, 0, 0, 0, 2'b11, 0, MODE_NONE, 0);
    check("ovr_first_valid", valid, 1);
    check("ovr_first_data", data, 8'h11);
    send_frame(8'h22, 0, 0, 0, 0, 2'b11, 0, MODE_NONE, 0);
    check("ovr_data_held", data, 8'h11);
    check("ovr_valid_held", valid, 1);
    check("ovr_pulse_count", ovr_cnt - ovr_base, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_clear", valid, 0);
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    check_sb("ovr");

    // Four-tick low glitch is a false start
    wait_ticks(1);
    @(negedge clk);
    rx_in = 1'b0;
    wait_ticks(2);
    #1;
    check("glitch_busy", busy, 1);
    wait_ticks(2);
    @(negedge clk);
    rx_in = 1'b1;
    wait_ticks(OVS);
    #1;
    check("glitch_idle", busy, 0);
    check("glitch_no_valid", valid, 0);
    check_sb("glitch");

    // Async reset during data bit 3 of 0x55, then a clean 0x66
    send_frame(8'h55, 0, 0, 0, 0, 2'b11, 0, MODE_ARST, 4);
    exp_q.push_back({8'h66, 1'b0, 1'b0});
    send_frame(8'h66, 0, 0, 0, 0, 2'b11, 0, MODE_NONE, 0);
    check_sb("arst_then_66");

    // rx_en dropped mid-frame discards it
    send_frame(8'h5A, 0, 0, 0, 0, 2'b11, 0, MODE_RXEN, 3);
    check("rx_en_no_valid", valid, 0);
    check_sb("rx_en_abort");

    // Synchronous reset clears a held frame
    ready = 1'b0;
    send_frame(8'h3C, 0, 0, 0, 0, 2'b11, 0, MODE_NONE, 0);
    check("srst_pre_valid", valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("srst_outputs", {data, valid, busy, frame_err, parity_err, overrun}, 0);
    @(negedge clk);
    rst   = 1'b0;
    ready = 1'b1;

    // Random frames against the model
    for (int f = 0; f < 8; f++) begin
      logic [WIDTH-1:0] w;
      bit pe, po, pb, s2;
      bit [1:0] sb;
      w     = WIDTH'($urandom);
      pe    = 1'($urandom);
      po    = 1'($urandom);
      pb    = 1'($urandom);
      s2    = 1'($urandom);
      sb[0] = ($urandom_range(0, 3) != 0);
      sb[1] = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(w, pe, po, pb, s2, sb));
      send_frame(w, pe, po, pb, s2, sb, 0, MODE_NONE, 0);
    end
    check_sb("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
